// File: rtl/nihilist_encrypt_stream.sv
// rtl/nihilist_encrypt_stream.sv - Nihilist cipher stream encryptor, two-stage valid/ready pipeline
// Optional build macro: LOWERCASE_FOLD_EN folds a-z to uppercase before the square lookup.
module nihilist_encrypt_stream #(
    parameter int SEC_LEN = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_err,
    output logic [7:0] err_count
);
    localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;

    // Returns {invalid, 10*row+col} for the MATEI/BCDFG/HKLNO/PQRSU/VWXYZ square.
    function automatic logic [6:0] square_lookup(input logic [7:0] ch);
        logic [7:0] c;
        c = ch;
`ifdef LOWERCASE_FOLD_EN
        if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
`endif
        case (c)
            "M": square_lookup = {1'b0, 6'd11};
            "A": square_lookup = {1'b0, 6'd12};
            "T": square_lookup = {1'b0, 6'd13};
            "E": square_lookup = {1'b0, 6'd14};
            "I", "J": square_lookup = {1'b0, 6'd15};
            "B": square_lookup = {1'b0, 6'd21};
            "C": square_lookup = {1'b0, 6'd22};
            "D": square_lookup = {1'b0, 6'd23};
            "F": square_lookup = {1'b0, 6'd24};
            "G": square_lookup = {1'b0, 6'd25};
            "H": square_lookup = {1'b0, 6'd31};
            "K": square_lookup = {1'b0, 6'd32};
            "L": square_lookup = {1'b0, 6'd33};
            "N": square_lookup = {1'b0, 6'd34};
            "O": square_lookup = {1'b0, 6'd35};
            "P": square_lookup = {1'b0, 6'd41};
            "Q": square_lookup = {1'b0, 6'd42};
            "R": square_lookup = {1'b0, 6'd43};
            "S": square_lookup = {1'b0, 6'd44};
            "U": square_lookup = {1'b0, 6'd45};
            "V": square_lookup = {1'b0, 6'd51};
            "W": square_lookup = {1'b0, 6'd52};
            "X": square_lookup = {1'b0, 6'd53};
            "Y": square_lookup = {1'b0, 6'd54};
            "Z": square_lookup = {1'b0, 6'd55};
            default: square_lookup = {1'b1, 6'd0};
        endcase
    endfunction

    // Key "PARASCHIV"; indices beyond 8 reuse the key cyclically.
    function automatic logic [5:0] key_lookup(input logic [KW-1:0] k);
        case (32'(k) % 32'd9)
            32'd0:   key_lookup = 6'd41;
            32'd1:   key_lookup = 6'd12;
            32'd2:   key_lookup = 6'd43;
            32'd3:   key_lookup = 6'd12;
            32'd4:   key_lookup = 6'd44;
            32'd5:   key_lookup = 6'd22;
            32'd6:   key_lookup = 6'd31;
            32'd7:   key_lookup = 6'd15;
            default: key_lookup = 6'd51;
        endcase
    endfunction

    logic [KW-1:0] key_idx;
    logic          s1_valid;
    logic [5:0]    s1_plain;
    logic [5:0]    s1_key;
    logic          s1_err;
    logic          s1_last;
    logic          advance;
    logic          accept;
    logic [6:0]    lookup_res;

    assign advance    = !out_valid || out_ready;
    assign in_ready   = !s1_valid || advance;
    assign accept     = in_valid && in_ready;
    assign lookup_res = square_lookup(in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_idx  <= '0;
            s1_valid <= 1'b0;
            s1_plain <= '0;
            s1_key   <= '0;
            s1_err   <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_plain <= lookup_res[5:0];
                s1_err   <= lookup_res[6];
                s1_key   <= key_lookup(key_idx);
                s1_last  <= in_last;
                // A message end restarts the key so the next message begins at key[0].
                if (in_last || key_idx == KW'(SEC_LEN - 1))
                    key_idx <= '0;
                else
                    key_idx <= key_idx + 1'b1;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_err ? 8'd0 : {2'b00, s1_plain} + {2'b00, s1_key};
                out_last <= s1_last;
                out_err  <= s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (out_valid && out_ready && out_err && err_count != 8'd255)
            err_count <= err_count + 8'd1;
    end
endmodule

// File: tb/tb_nihilist_encrypt_stream.sv
// tb/tb_nihilist_encrypt_stream.sv - directed self-checking bench for nihilist_encrypt_stream
module tb_nihilist_encrypt_stream;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_err;
    logic [7:0] err_count;

    int compared   = 0;
    int mismatched = 0;
    logic [9:0] beats[$];

    always #5 clk = ~clk;

    nihilist_encrypt_stream #(.SEC_LEN(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_err(out_err), .err_count(err_count)
    );

    // out_ready only changes just after a rising edge, so a handshake seen here completes next edge.
    always @(negedge clk)
        if (rst_n && out_valid && out_ready) beats.push_back({out_last, out_err, out_data});

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", t, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'hXX;
    endtask

    task automatic send_msg(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], i == s.len() - 1);
    endtask

    task automatic drain(input int n);
        int t = 0;
        while (beats.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_count", beats.size(), n);
    endtask

    task automatic expect_beat(input string tag, input int data, input int last, input int err);
        logic [9:0] b;
        if (beats.size() == 0) begin
            chk({tag, "_missing"}, 0, 1);
        end else begin
            b = beats.pop_front();
            chk({tag, "_data"}, int'(b[7:0]), data);
            chk({tag, "_last"}, int'(b[9]), last);
            chk({tag, "_err"}, int'(b[8]), err);
        end
    endtask

    int exp_attack[6] = '{53, 25, 56, 24, 66, 54};
    int exp_m[10]     = '{52, 23, 54, 23, 55, 33, 42, 26, 62, 52};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Latency: single "A" appears two edges after acceptance.
        send("A", 1'b1);
        @(negedge clk);
        chk("lat_s1_only", out_valid, 0);
        @(negedge clk);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_data", out_data, 53);
        chk("lat_out_last", out_last, 1);
        @(negedge clk);
        beats.delete();

        send_msg("ATTACK");
        drain(6);
        for (int i = 0; i < 6; i++) expect_beat("attack", exp_attack[i], (i == 5) ? 1 : 0, 0);

        send_msg("MMMMMMMMMM");
        drain(10);
        for (int i = 0; i < 10; i++) expect_beat("m_wrap", exp_m[i], (i == 9) ? 1 : 0, 0);

        send_msg("AB");
        send_msg("A");
        drain(3);
        expect_beat("ab_a0", 53, 0, 0);
        expect_beat("ab_b", 33, 1, 0);
        expect_beat("ab_a1", 53, 1, 0);

        send("1", 1'b0);
        send("J", 1'b1);
        drain(2);
        expect_beat("bad_char", 0, 0, 1);
        expect_beat("j_as_i", 27, 1, 0);
        chk("err_count_1", err_count, 1);

        send("a", 1'b1);
        drain(1);
        expect_beat("lowercase", 0, 1, 1);
        chk("err_count_2", err_count, 2);

        // Backpressure: downstream stalls with both stages full.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send("A", 1'b0);
        send("T", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 53);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send("T", 1'b0);
        send("A", 1'b0);
        send("C", 1'b0);
        send("K", 1'b1);
        drain(6);
        for (int i = 0; i < 6; i++) expect_beat("bp_attack", exp_attack[i], (i == 5) ? 1 : 0, 0);

        for (int i = 0; i < 260; i++) send("1", 1'b0);
        drain(260);
        beats.delete();
        chk("err_count_sat", err_count, 255);

        // Reset mid-message discards in-flight beats.
        send("A", 1'b0);
        send("T", 1'b0);
        send("T", 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_out_err", out_err, 0);
        chk("mid_rst_err_count", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        beats.delete();
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        send("A", 1'b1);
        drain(1);
        expect_beat("post_rst_a", 53, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
